// File: rtl/logic_pkg.sv
// Shared definitions for the registered logic unit: op codes and the
// skid-buffer occupancy encoding.
package logic_pkg;

  localparam logic [2:0] OP_NAND  = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_NOR   = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_NOT   = 3'd6;
  localparam logic [2:0] OP_RNAND = 3'd7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit logic op decoder with zero / all-ones flags
// describing the produced result.
module logic_op_core
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             ones
);

  logic rnand;
  assign rnand = ~(&a);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      // Reduction NAND lands in bit 0 only; upper bits read as zero.
      localparam bit IS_LSB = (gi == 0);
      logic bit_v;
      always_comb begin
        bit_v = 1'b0;
        case (op)
          OP_NAND:  bit_v = ~(a[gi] & b[gi]);
          OP_AND:   bit_v = a[gi] & b[gi];
          OP_OR:    bit_v = a[gi] | b[gi];
          OP_NOR:   bit_v = ~(a[gi] | b[gi]);
          OP_XOR:   bit_v = a[gi] ^ b[gi];
          OP_XNOR:  bit_v = ~(a[gi] ^ b[gi]);
          OP_NOT:   bit_v = ~a[gi];
          OP_RNAND: bit_v = IS_LSB ? rnand : 1'b0;
          default:  bit_v = 1'b0;
        endcase
      end
      assign res[gi] = bit_v;
    end
  endgenerate

  assign zero = (res == '0);
  assign ones = &res;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit: op result plus flags captured at accept time, held in
// a 2-entry skid buffer behind valid/ready, with a saturating handshake count.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic               out_ones,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] txn_count
);

  // Entry layout: {data, zero, ones}
  localparam int EW = WIDTH + 2;

  logic [WIDTH-1:0]   core_res;
  logic               core_zero;
  logic               core_ones;
  logic [EW-1:0]      new_entry;
  logic [EW-1:0]      main_reg;
  logic [EW-1:0]      skid_reg;
  logic [COUNT_W-1:0] cnt_reg;
  state_t             state_reg;
  state_t             state_next;
  logic               load_main_new;
  logic               load_main_skid;
  logic               load_skid;
  logic               accept;
  logic               pop;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a    (a),
    .b    (b),
    .op   (op),
    .res  (core_res),
    .zero (core_zero),
    .ones (core_ones)
  );

  assign new_entry = {core_res, core_zero, core_ones};

  assign in_ready  = !rst && (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = main_reg[EW-1:2];
  assign out_zero  = main_reg[1];
  assign out_ones  = main_reg[0];
  assign txn_count = cnt_reg;

  always_comb begin
    state_next     = state_reg;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next    = ONE;
          load_main_new = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main_new = 1'b1;
        end else if (accept) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can move us
        if (pop) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (load_main_new) begin
        main_reg <= new_entry;
      end else if (load_main_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= new_entry;
      end
      // Clear wins over a coincident pop
      if (cnt_clr) begin
        cnt_reg <= '0;
      end else if (pop && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the single-bit 2-input gate.
- Applies one of eight selectable bitwise/reduction logic ops, NAND being op 0, to two WIDTH-bit operands.
- Result is buffered behind a valid/ready handshake with a 2-entry skid buffer, so it drops into streaming datapaths at full throughput.
- Also keeps a saturating count of completed transactions and reports zero/all-ones flags.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- COUNT_W, 16, width of the transaction counter (>=2).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored by ops 6, 7)
- op  input  3  operation select, sampled with a/b
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  result
- out_zero  output  1  out_data == 0
- out_ones  output  1  out_data == all ones
- cnt_clr  input  1  synchronous clear of txn_count
- txn_count  output  COUNT_W  number of output handshakes, saturating

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset values: state EMPTY, out_valid=0, out_data=0, out_zero=0, out_ones=0, txn_count=0, skid contents=0.
- While rst=1, in_ready=0 and inputs are ignored.
- Op encoding:
  - 000 NAND ~(a&b)
  - 001 AND
  - 010 OR
  - 011 NOR
  - 100 XOR
  - 101 XNOR
  - 110 NOT a
  - 111 reduction NAND of a, result in bit 0, upper bits 0
- Result and both flags are computed combinationally from a/b/op at accept time and stored with the entry. Flags always describe the entry currently presented.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- States: EMPTY (no entry), ONE (main register valid), FULL (main + skid valid).
  - in_ready = !rst & (state != FULL)
  - out_valid = (state != EMPTY)
  - out_data, out_zero and out_ones come from the main register.
- Transitions:
  - EMPTY: accept -> ONE, main <= new.
  - ONE: accept & pop -> ONE, main <= new.
  - ONE: accept & !pop -> FULL, skid <= new.
  - ONE: !accept & pop -> EMPTY.
  - FULL: pop -> ONE, main <= skid. No accept possible in FULL.
  - Otherwise hold.
- Latency: operands accepted in cycle N appear with out_valid=1 in cycle N+1 when not stalled. Throughput is 1 per cycle with out_ready held high.
- Ordering: results leave strictly in acceptance order. No drop, no duplication.
- While out_valid=1 and out_ready=0, out_data and flags are stable.
- txn_count:
  - +1 on each pop; holds at 2^COUNT_W-1.
  - cnt_clr has priority over increment: clear + pop in the same cycle -> 0.
  - rst clears it.
- Reset mid-operation, any state: all entries discarded, outputs take reset values the next cycle.

Decomposition:
- Shared package logic_pkg holds:
  - op code constants OP_NAND..OP_RNAND
  - state encoding EMPTY/ONE/FULL
- One natural sub-module: logic_op_core, a combinational WIDTH-bit op decoder plus zero/ones flag generation, instantiated once at the input side.
- Skid control and counter stay in logic_unit_pipe.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, a=8'hFF -> in_ready=0, out_valid=0, out_data=0, txn_count=0. After release, in_ready=1.
- NAND: op=0, a=8'hF0, b=8'h3C, out_ready=1 -> next cycle out_data=8'hCF, out_zero=0, out_ones=0, txn_count=1.
- Op sweep: a=8'hAA, b=8'h0F, ops 1..6 -> 8'h0A, 8'hAF, 8'h50, 8'hA5, 8'h5A, 8'h55.
- Reduction NAND, op=7:
  - a=8'hFF -> out_data=0, out_zero=1.
  - a=8'hFE -> out_data=8'h01.
- Backpressure:
  - Setup: out_ready=0, three back-to-back NAND inputs (a=1,2,3; b=8'hFF).
  - First two accepted; in_ready=0 once FULL; third held.
  - Raise out_ready: outputs 8'hFE, 8'hFD, 8'hFC in order, one per cycle.
  - out_data stable while stalled.
- Counter (COUNT_W=4):
  - 17 handshakes -> txn_count=15.
  - cnt_clr asserted with a pop in the same cycle -> 0.
- Reset in FULL -> next cycle out_valid=0, in_ready=1 once rst drops, held entries never appear.
